// File: rtl/key_debounce_if.sv
// Push-button debouncer bundle: the raw active-low key levels go in, and the
// debounced level plus press/release pulses come out.
interface key_debounce_if;
  logic [3:0] KEY;        // raw, asynchronous, active-low, bouncing
  logic [3:0] key_level;  // debounced pressed state, active-high
  logic [3:0] key_rise;   // one-cycle pulse on an accepted press
  logic [3:0] key_fall;   // one-cycle pulse on an accepted release

  // Drives the buttons and observes the debounced result.
  modport master (
    output KEY,
    input  key_level,
    input  key_rise,
    input  key_fall
  );

  // The debouncer itself.
  modport slave (
    input  KEY,
    output key_level,
    output key_rise,
    output key_fall
  );
endinterface

// File: rtl/key_debounce.sv
// Four-key push-button debouncer.
// Each raw key is brought into the clock domain through a two-flop
// synchronizer. It is then filtered by its own four-state FSM, which accepts a
// level change only after DEBOUNCE_CYCLES consecutive agreeing samples. The
// debounced level and the press/release pulses are all registered, so they
// change together one cycle after the accepting edge.
// Reset release is assumed to be synchronized to clk outside this block.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000  // N, must be >= 2
) (
  input logic      clk,
  input logic      rst_n,
  key_debounce_if.slave kif
);

  localparam int N  = DEBOUNCE_CYCLES;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    s;          // synchronized, 1 = pressed
  state_t        state     [4];
  state_t        state_nxt [4];
  logic [CW-1:0] cnt       [4];
  logic [CW-1:0] cnt_nxt   [4];
  logic [3:0]    level_nxt;
  logic [3:0]    level_q;
  logic [3:0]    rise_q;
  logic [3:0]    fall_q;

  // Two-flop synchronizer per key. It resets to the released level, so a key
  // held across reset looks like a fresh press once reset lifts.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= kif.KEY;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Next-state and counter logic. Every key runs the same independent FSM.
  // A pending state counts consecutive samples of the new level, and the
  // counter stops at N-1 because reaching it forces a state change.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = '0;
      level_nxt[i] = 1'b0;
      unique case (state[i])
        RELEASED: begin
          if (s[i]) begin
            state_nxt[i] = PRESS_PEND;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        PRESS_PEND: begin
          if (!s[i]) begin
            state_nxt[i] = RELEASED;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = PRESSED;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_nxt[i] = RELEASE_PEND;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (s[i]) begin
            state_nxt[i] = PRESSED;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = RELEASED;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = RELEASED;
        end
      endcase
      level_nxt[i] = (state_nxt[i] == PRESSED) || (state_nxt[i] == RELEASE_PEND);
    end
  end

  // FSM state and counter registers. Reset discards any pending count.
  // NOTE: the per-key state and counter arrays are real control registers and
  // must be reset; they cannot be left to power-up values like a storage RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Registered outputs. They are computed from the next state, so the level
  // and its edge pulse change in the same cycle. Rise and fall are exclusive
  // because level_nxt cannot both set and clear a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      level_q <= level_nxt;
      rise_q  <= level_nxt & ~level_q;
      fall_q  <= ~level_nxt & level_q;
    end
  end

  assign kif.key_level = level_q;
  assign kif.key_rise  = rise_q;
  assign kif.key_fall  = fall_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with N = 4.
// The reference model is a two-sample delay line on the raw keys. After it,
// each key's accepted level flips once N consecutive delayed samples disagree
// with that level. Directed scenarios pin the model with literal expectations,
// and randomized bouncing follows.
module tb_key_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  key_debounce_if kif ();

  key_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] d1, d2;           // raw key delayed by one and two edges
  logic [3:0] m_level, m_rise, m_fall;
  int         run [4];          // consecutive samples disagreeing with m_level

  function automatic int step_run(input int r, input logic smp, input logic lvl);
    return (smp != lvl) ? r + 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1      <= 4'hF;
      d2      <= 4'hF;
      m_level <= 4'h0;
      m_rise  <= 4'h0;
      m_fall  <= 4'h0;
      for (int i = 0; i < 4; i++) run[i] <= 0;
    end else begin
      d1 <= kif.KEY;
      d2 <= d1;
      for (int i = 0; i < 4; i++) begin
        if (step_run(run[i], ~d2[i], m_level[i]) == N) begin
          run[i]     <= 0;
          m_level[i] <= ~m_level[i];
          m_rise[i]  <= ~m_level[i];
          m_fall[i]  <= m_level[i];
        end else begin
          run[i]    <= step_run(run[i], ~d2[i], m_level[i]);
          m_rise[i] <= 1'b0;
          m_fall[i] <= 1'b0;
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("level_vs_model", kif.key_level, m_level);
    check("rise_vs_model",  kif.key_rise,  m_rise);
    check("fall_vs_model",  kif.key_fall,  m_fall);
  end

  int rise1_cnt = 0;
  int fall2_cnt = 0;
  always @(negedge clk) begin
    if (kif.key_rise[1]) rise1_cnt++;
    if (kif.key_fall[2]) fall2_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    kif.KEY = 4'hF;
    rst_n   = 1'b0;
    cycles(3);
    check("reset_level", kif.key_level, 4'h0);
    check("reset_rise",  kif.key_rise,  4'h0);
    check("reset_fall",  kif.key_fall,  4'h0);
    rst_n = 1'b1;
    cycles(8);

    // Clean press of key 0: accepted on the 6th edge.
    kif.KEY = 4'b1110;
    cycles(5);
    check("press0_before", kif.key_level, 4'b0000);
    cycles(1);
    check("press0_level", kif.key_level, 4'b0001);
    check("press0_rise",  kif.key_rise,  4'b0001);
    cycles(1);
    check("press0_rise_once", kif.key_rise,  4'b0000);
    check("press0_hold",      kif.key_level, 4'b0001);

    // Bounce on key 1: 3 pressed, 1 released, then held.
    rise1_cnt = 0;
    kif.KEY[1] = 1'b0;
    cycles(3);
    kif.KEY[1] = 1'b1;
    cycles(1);
    kif.KEY[1] = 1'b0;
    cycles(5);
    check("bounce1_before", {3'b0, kif.key_level[1]}, 4'd0);
    check("bounce1_no_early", rise1_cnt[3:0], 4'd0);
    cycles(1);
    check("bounce1_rise", kif.key_rise, 4'b0010);
    cycles(2);
    check("bounce1_single", rise1_cnt[3:0], 4'd1);

    // Release of key 2, first with a re-press glitch in RELEASE_PEND.
    kif.KEY[2] = 1'b0;
    cycles(10);
    fall2_cnt = 0;
    kif.KEY[2] = 1'b1;
    cycles(2);
    kif.KEY[2] = 1'b0;
    cycles(10);
    check("glitch2_level", {3'b0, kif.key_level[2]}, 4'd1);
    check("glitch2_nofall", fall2_cnt[3:0], 4'd0);
    kif.KEY[2] = 1'b1;
    cycles(5);
    check("release2_before", {3'b0, kif.key_level[2]}, 4'd1);
    cycles(1);
    check("release2_fall",  kif.key_fall, 4'b0100);
    check("release2_level", {3'b0, kif.key_level[2]}, 4'd0);

    // Simultaneous press of all keys.
    kif.KEY = 4'hF;
    cycles(10);
    kif.KEY = 4'h0;
    cycles(5);
    check("simul_before", kif.key_rise, 4'h0);
    cycles(1);
    check("simul_rise", kif.key_rise, 4'hF);
    cycles(1);
    check("simul_level", kif.key_level, 4'hF);

    // Reset in the middle of key 3's PRESS_PEND, key held throughout.
    kif.KEY = 4'hF;
    cycles(10);
    kif.KEY = 4'b0111;
    cycles(4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_level", kif.key_level, 4'h0);
    check("rst_mid_rise",  kif.key_rise,  4'h0);
    check("rst_mid_fall",  kif.key_fall,  4'h0);
    cycles(1);
    #2 rst_n = 1'b1;
    cycles(5);
    check("rst_rel_before", kif.key_rise, 4'h0);
    cycles(1);
    check("rst_rel_rise",  kif.key_rise,  4'b1000);
    check("rst_rel_level", kif.key_level, 4'b1000);

    // Randomized bouncing: toggle random keys, hold 1..7 cycles, rare resets.
    kif.KEY = 4'hF;
    cycles(10);
    for (int seg = 0; seg < 600; seg++) begin
      kif.KEY = kif.KEY ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        cycles(1);
        #2 rst_n = 1'b1;
      end
      cycles($urandom_range(1, 7));
    end
    kif.KEY = 4'hF;
    cycles(12);
    check("final_released", kif.key_level, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable synchronized samples (N) required to accept a level change; legal range N >= 2.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port KEY, input, 4, the raw push-button levels: asynchronous to clk, active-low (0 = pressed), bouncing.
REQ-005 The block SHALL have port key_level, output, 4, the debounced active-high pressed state per key.
REQ-006 The block SHALL have port key_rise, output, 4, a one-cycle pulse per key on accepted press.
REQ-007 The block SHALL have port key_fall, output, 4, a one-cycle pulse per key on accepted release.

Function
REQ-008 Each KEY bit SHALL pass through its own two-flop synchronizer before any other logic; no other logic SHALL sample raw KEY.
REQ-009 The block SHALL invert the synchronized value so that s[i] = 1 means pressed.
REQ-010 Each key SHALL have an independent FSM with states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND and a counter of width $clog2(N+1).
REQ-011 In RELEASED with s=1, the FSM SHALL go to PRESS_PEND with cnt=1; with s=0 it SHALL stay in RELEASED with cnt=0.
REQ-012 In PRESS_PEND with s=0, the FSM SHALL return to RELEASED with cnt=0 and produce no output change.
REQ-013 In PRESS_PEND with s=1 and cnt=N-1, the FSM SHALL go to PRESSED.
REQ-014 In PRESS_PEND with s=1 and cnt<N-1, the FSM SHALL increment cnt.
REQ-015 PRESSED and RELEASE_PEND SHALL mirror REQ-011 to REQ-014 with s inverted: RELEASE_PEND reaching N samples of s=0 SHALL go to RELEASED; any s=1 SHALL return to PRESSED.
REQ-016 key_level[i] SHALL be registered and equal 1 exactly while the FSM is in PRESSED or RELEASE_PEND.
REQ-017 key_rise[i] SHALL be registered and high for exactly one cycle, the first cycle key_level[i] is 1.
REQ-018 key_fall[i] SHALL be registered and high for exactly one cycle, the first cycle key_level[i] is 0 after being 1.
REQ-019 key_rise[i] and key_fall[i] SHALL never be high in the same cycle.
REQ-020 Latency: with KEY[i] changed and held stable, key_level[i] and key_rise[i] (or key_fall[i]) SHALL change in the cycle after the (N+2)th rising edge following the raw change, i.e. 2 synchronizer edges plus N counting edges.
REQ-021 Any bounce shorter than N consecutive synchronized samples SHALL produce no change on any output.
REQ-022 The counter SHALL saturate by construction: it never exceeds N-1 and never wraps.
REQ-023 The four keys SHALL be fully independent; simultaneous presses SHALL produce simultaneous key_rise bits with identical timing.

Reset
REQ-024 On rst_n=0, asynchronously: synchronizer flops SHALL be set to 1 (released), all FSMs SHALL be RELEASED, all counters 0, and key_level, key_rise and key_fall SHALL all be 4'b0000.
REQ-025 Asserting reset mid-PRESS_PEND or mid-RELEASE_PEND SHALL discard the pending count, with no pulse emitted.
REQ-026 A key held pressed across reset deassertion SHALL be treated as a new press, giving key_rise N+2 edges after rst_n rises.
REQ-027 Reset deassertion SHALL be synchronized externally; the block SHALL not include a reset synchronizer.

Verification (N=4)
REQ-028 Clean press: KEY[0] goes 1->0 and is held -> key_level[0]=1 and key_rise[0]=1 for one cycle after 6 edges; key_rise[0]=0 thereafter; other bits stay 0.
REQ-029 Bounce: KEY[1] pressed for 3 synchronized cycles, released for 1, then held -> a single key_rise[1], 6 edges after the final 1->0 transition; no earlier pulse.
REQ-030 Release: from PRESSED, KEY[2] goes 0->1 -> key_fall[2] pulses once and key_level[2]=0 after 6 edges; a 2-cycle re-press glitch during RELEASE_PEND leaves key_level[2]=1 and no key_fall.
REQ-031 Simultaneous: KEY 4'b1111 -> 4'b0000 -> key_rise=4'b1111 in a single cycle, then key_level=4'b1111.
REQ-032 Reset mid-operation: rst_n pulsed low during PRESS_PEND of KEY[3] with the key still held -> all outputs 0 immediately; key_rise[3] occurs 6 edges after rst_n rises.
